// File: rtl/sort_pkg.sv
// ============================================================================
// sort_pkg : state encoding and mux-select encodings for the sort controller
// Rev 1.0
// ============================================================================
`default_nettype none

package sort_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_RD_A  = 4'd1,
    S_LD_A  = 4'd2,
    S_RD_B  = 4'd3,
    S_LD_B  = 4'd4,
    S_CMP   = 4'd5,
    S_SW_J  = 4'd6,
    S_SW_I  = 4'd7,
    S_RL_A  = 4'd8,
    S_RLD_A = 4'd9,
    S_NXT   = 4'd10,
    S_DONE  = 4'd11
  } sort_state_t;

  localparam logic SEL_I = 1'b0;
  localparam logic SEL_J = 1'b1;
  localparam logic OUT_A = 1'b0;
  localparam logic OUT_B = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sort_ctrl.sv
// ============================================================================
// sort_ctrl : FSM sequencing an in-place ascending exchange sort datapath.
// Optional swap counter enabled by defining SORT_SWAP_CNT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module sort_ctrl
  import sort_pkg::*;
#(
  parameter int L   = 4,
  parameter int SCW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic           zi,
  input  logic           zj,
  input  logic           AgtB,
  output logic           busy,
  output logic           done,
  output logic           Wr,
  output logic           Li,
  output logic           Ei,
  output logic           Lj,
  output logic           Ej,
  output logic           EA,
  output logic           EB,
  output logic           Csel,
  output logic           Bout
`ifdef SORT_SWAP_CNT_EN
  ,
  output logic [SCW-1:0] swap_cnt
`endif
);

  // The counter must be able to hold K*(K-1)/2 swaps without saturating.
  generate
    if (((2 ** SCW) - 1) < (((2 ** L) * ((2 ** L) - 1)) / 2)) begin : g_scw_check
      $error("sort_ctrl: SCW too narrow for K*(K-1)/2 swaps");
    end
  endgenerate

  sort_state_t state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go) state_d = S_RD_A;
      S_RD_A:  state_d = S_LD_A;
      S_LD_A:  state_d = S_RD_B;
      S_RD_B:  state_d = S_LD_B;
      S_LD_B:  state_d = S_CMP;
      S_CMP:   state_d = AgtB ? S_SW_J : S_NXT;
      S_SW_J:  state_d = S_SW_I;
      S_SW_I:  state_d = S_RL_A;
      S_RL_A:  state_d = S_RLD_A;
      S_RLD_A: state_d = S_NXT;
      S_NXT: begin
        if (!zj)      state_d = S_RD_B;
        else if (!zi) state_d = S_RD_A;
        else          state_d = S_DONE;
      end
      S_DONE:  if (!go) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b1;
    done = 1'b0;
    Wr   = 1'b0;
    Li   = 1'b0;
    Ei   = 1'b0;
    Lj   = 1'b0;
    Ej   = 1'b0;
    EA   = 1'b0;
    EB   = 1'b0;
    Csel = SEL_I;
    Bout = OUT_A;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        Li   = 1'b1;
      end
      S_RD_A:  Lj = 1'b1;
      S_LD_A:  EA = 1'b1;
      S_RD_B:  Csel = SEL_J;
      S_LD_B: begin
        Csel = SEL_J;
        EB   = 1'b1;
      end
      S_CMP:   Csel = SEL_J;
      S_SW_J: begin
        Csel = SEL_J;
        Bout = OUT_A;
        Wr   = 1'b1;
      end
      S_SW_I: begin
        Csel = SEL_I;
        Bout = OUT_B;
        Wr   = 1'b1;
      end
      S_RL_A:  Csel = SEL_I;
      // Reload A so later compares in this pass use the swapped-in M[i].
      S_RLD_A: EA = 1'b1;
      S_NXT: begin
        if (!zj)      Ej = 1'b1;
        else if (!zi) Ei = 1'b1;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

`ifdef SORT_SWAP_CNT_EN
  logic [SCW-1:0] swap_cnt_q, swap_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) swap_cnt_q <= '0;
    else     swap_cnt_q <= swap_cnt_d;
  end

  always_comb begin
    swap_cnt_d = swap_cnt_q;
    if (state_q == S_IDLE && go)
      swap_cnt_d = '0;
    else if (state_q == S_SW_J && !(&swap_cnt_q))
      swap_cnt_d = swap_cnt_q + 1'b1;
  end

  assign swap_cnt = swap_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sort_ctrl.sv
// ============================================================================
// tb_sort_ctrl : sort_ctrl driving a behavioural RAM/counter/register datapath
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sort_ctrl;

  localparam int L   = 4;
  localparam int K   = 16;
  localparam int SCW = 8;
  localparam int DW  = 16;

  typedef logic [K-1:0][DW-1:0] mem_t;

  typedef struct {
    int kind;
    int exp_cycles;
    int exp_wr;
  } vec_t;

  typedef struct {
    int   cycles;
    int   wrs;
    int   swaps;
    mem_t data;
  } exp_t;

  logic clk = 1'b0;
  logic rst, go;
  logic zi, zj, AgtB;
  logic busy, done, Wr, Li, Ei, Lj, Ej, EA, EB, Csel, Bout;
  logic [SCW-1:0] swap_cnt;

  always #5 clk = ~clk;

  sort_ctrl #(.L(L), .SCW(SCW)) dut (
    .clk(clk), .rst(rst), .go(go), .zi(zi), .zj(zj), .AgtB(AgtB),
    .busy(busy), .done(done), .Wr(Wr), .Li(Li), .Ei(Ei), .Lj(Lj), .Ej(Ej),
    .EA(EA), .EB(EB), .Csel(Csel), .Bout(Bout)
`ifdef SORT_SWAP_CNT_EN
    , .swap_cnt(swap_cnt)
`endif
  );

`ifndef SORT_SWAP_CNT_EN
  assign swap_cnt = '0;
`endif

  // Datapath model: counters, synchronous-read RAM, A/B registers, comparator.
  logic [DW-1:0] ram [K];
  logic [L-1:0]  ri = '0, rj = '0;
  logic [DW-1:0] mout = '0, ra = '0, rb = '0;
  logic          ld_en = 1'b0;
  logic [L-1:0]  ld_addr = '0;
  logic [DW-1:0] ld_data = '0;

  always @(posedge clk) begin
    if (Li) ri <= '0;
    else if (Ei) ri <= ri + 1'b1;
    if (Lj) rj <= ri + 1'b1;
    else if (Ej) rj <= rj + 1'b1;
    mout <= ram[Csel ? rj : ri];
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (Wr) ram[Csel ? rj : ri] <= Bout ? rb : ra;
    if (EA) ra <= mout;
    if (EB) rb <= mout;
  end

  assign zi   = (ri == L'(K - 2));
  assign zj   = (rj == L'(K - 1));
  assign AgtB = (ra > rb);

  // Sticky protocol-violation counter, checked once at the end.
  int viol = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (Ei && Ej) viol <= viol + 1;
      else if (Wr && !busy) viol <= viol + 1;
      else if ((Li || Lj) && (Ei || Ej)) viol <= viol + 1;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;
  exp_t sb[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic mem_t make_mem(input int kind);
    mem_t m;
    for (int k = 0; k < K; k++) begin
      case (kind)
        0:       m[k] = DW'(k);
        1:       m[k] = DW'(K - 1 - k);
        2:       m[k] = 16'h00AA;
        default: m[k] = DW'($urandom_range(0, 7));
      endcase
    end
    return m;
  endfunction

  // Reference exchange sort: for each i, swap with every later j holding a smaller value.
  task automatic ref_sort(input mem_t din, output mem_t dout, output int swaps);
    logic [DW-1:0] t;
    dout  = din;
    swaps = 0;
    for (int a = 0; a < K - 1; a++)
      for (int b = a + 1; b < K; b++)
        if (dout[a] > dout[b]) begin
          t = dout[a]; dout[a] = dout[b]; dout[b] = t;
          swaps++;
        end
  endtask

  task automatic load_ram(input mem_t m);
    for (int k = 0; k < K; k++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_addr = L'(k); ld_data = m[k];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  function automatic logic [10:0] ctl_vec();
    return {busy, done, Wr, Li, Ei, Lj, Ej, EA, EB, Csel, Bout};
  endfunction

  task automatic run_sort(input string tag, input mem_t init, input int exp_cyc, input int exp_wr);
    exp_t e, got;
    int cyc, wrs, n;
    load_ram(init);
    ref_sort(init, e.data, e.swaps);
    e.cycles = (exp_cyc < 0) ? 510 + 4 * e.swaps : exp_cyc;
    e.wrs    = (exp_wr  < 0) ? 2 * e.swaps : exp_wr;
    sb.push_back(e);
    go = 1'b1;
    cyc = 0; wrs = 0; n = 0;
    @(negedge clk);
    chk({tag, "_first_rd_a"}, {busy, Lj, Csel, done}, 4'b1100);
    while (!done && n < 3000) begin
      if (busy) cyc++;
      if (Wr) wrs++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, done, 1);
    got = sb.pop_front();
    chk({tag, "_busy_cycles"}, cyc, got.cycles);
    chk({tag, "_wr_cycles"}, wrs, got.wrs);
`ifdef SORT_SWAP_CNT_EN
    chk({tag, "_swap_cnt"}, swap_cnt, got.swaps);
`endif
    for (int k = 0; k < K; k++)
      chk($sformatf("%s_ram[%0d]", tag, k), ram[k], got.data[k]);
    n = 0;
    for (int k = 1; k < K; k++) if (ram[k] < ram[k-1]) n++;
    chk({tag, "_nondecreasing"}, n, 0);
    // Holding go keeps the controller parked in DONE.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk({tag, "_hold_done"}, {busy, done}, 2'b01);
    end
    go = 1'b0;
    @(negedge clk);
    chk({tag, "_back_idle"}, ctl_vec(), 11'b00010000000);
  endtask

  initial begin
    vec_t vecs[4];
    mem_t m;
    int n;
    vecs[0] = '{0, 510, 0};
    vecs[1] = '{1, 990, 240};
    vecs[2] = '{2, 510, 0};
    vecs[3] = '{3, -1, -1};

    rst = 1'b1; go = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", ctl_vec(), 11'b00010000000);
    chk("reset_swap_cnt", swap_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_go", ctl_vec(), 11'b00010000000);

    for (int v = 0; v < 4; v++)
      run_sort($sformatf("vec%0d", vecs[v].kind), make_mem(vecs[v].kind),
               vecs[v].exp_cycles, vecs[v].exp_wr);

    // Asynchronous reset in the middle of a reverse-order sort.
    load_ram(make_mem(1));
    go = 1'b1;
    repeat (200) @(negedge clk);
    chk("mid_busy_before_rst", busy, 1);
    #2 rst = 1'b1;
    #1 chk("mid_rst_outputs", ctl_vec(), 11'b00010000000);
    chk("mid_rst_swap_cnt", swap_cnt, 0);
    go = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", ctl_vec(), 11'b00010000000);
    run_sort("after_rst", make_mem(1), 990, 240);

    // Random run with duplicates, then immediate restart from IDLE.
    run_sort("rand2", make_mem(3), -1, -1);
    go = 1'b1;
    @(negedge clk);
    chk("restart_busy", {busy, Lj}, 2'b11);
    n = 0;
    while (!done && n < 3000) begin @(negedge clk); n++; end
    chk("restart_done", done, 1);
    go = 1'b0;
    @(negedge clk);
    chk("restart_idle", {busy, done, Li}, 3'b001);

    chk("protocol_violations", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sort_ctrl.md
Name: sort_ctrl

Overview:
- FSM controller that sequences the sorting datapath (counters i/j, RAM, registers A/B, A>B comparator).
- Performs an in-place ascending exchange sort of K=2**L words held in the datapath RAM.
- Drives every datapath control input plus the datapath start (address/data mux select) through the busy output.
- Reports completion to the host through done.

Parameters:
- L, 4, width of datapath counters/addresses; K = 2**L words sorted (datapath zi/zj terminal values are K-2/K-1).
- SCW, 8, width of optional swap counter; must hold K*(K-1)/2 (120 for L=4).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- go  in  1  host request to sort; level, sampled in IDLE and DONE
- zi  in  1  datapath flag, i == K-2
- zj  in  1  datapath flag, j == K-1
- AgtB  in  1  datapath flag, regA > regB
- busy  out  1  high while sorting; drives datapath start (RAM address/data from counters and A/B mux)
- done  out  1  sort complete; held high until go deasserts
- Wr  out  1  RAM write
- Li  out  1  load i with 0
- Ei  out  1  increment i
- Lj  out  1  load j with i+1
- Ej  out  1  increment j
- EA  out  1  load regA from RAM output
- EB  out  1  load regB from RAM output
- Csel  out  1  0 selects address i, 1 selects address j
- Bout  out  1  write data: 0 selects regA, 1 selects regB
- swap_cnt  out  SCW  swaps performed (SORT_SWAP_CNT_EN only)

Behaviour:
- RAM read is synchronous: an address presented in cycle t gives valid Mij in cycle t+1, so every load uses an address state followed by a load state. The address is held in both states.
- States: IDLE, RD_A, LD_A, RD_B, LD_B, CMP, SW_J, SW_I, RL_A, RLD_A, NXT, DONE. Outputs are Moore (decoded from state) unless noted. All unlisted controls are 0.
- IDLE: Li=1. On go=1, go to RD_A.
- RD_A: Csel=0, Lj=1. Go to LD_A.
- LD_A: Csel=0, EA=1. Go to RD_B.
- RD_B: Csel=1. Go to LD_B.
- LD_B: Csel=1, EB=1. Go to CMP.
- CMP: Csel=1. If AgtB, go to SW_J; otherwise go to NXT.
- SW_J: Csel=1, Bout=0, Wr=1 (M[j] <= A). Go to SW_I.
- SW_I: Csel=0, Bout=1, Wr=1 (M[i] <= B). Go to RL_A.
- RL_A: Csel=0. Go to RLD_A.
- RLD_A: Csel=0, EA=1 (A <= new M[i]). Go to NXT.
- NXT (flags evaluated in the same cycle):
  - zj=0: Ej=1, go to RD_B.
  - zj=1 and zi=0: Ei=1, go to RD_A.
  - zj=1 and zi=1: go to DONE.
- DONE: done=1. Stay while go=1; go to IDLE when go=0. A new sort therefore requires go to be deasserted and then reasserted.
- busy=1 in every state except IDLE and DONE.
- Ei and Ej are never asserted in the same cycle. Li and Lj are never asserted together with Ei or Ej.
- Cycle count for K=16: 30 outer cycles (RD_A, LD_A × 15) + 480 inner cycles (4 × 120 pairs) + 4 per swap. Minimum 510 busy cycles, maximum 990.
- Reset: asynchronous, at any point including mid-sort. State goes to IDLE, all outputs go to 0 except Li=1 (IDLE decode), and swap_cnt clears. RAM contents after a reset mid-sort are undefined. The host must rerun the sort.
- go changes while busy are ignored.

Optional Feature:
- SORT_SWAP_CNT_EN defined:
  - swap_cnt is an SCW-bit register, cleared on rst and on the IDLE→RD_A transition.
  - Increments by 1 in each SW_J cycle and saturates at all-ones.
  - Holds its value in DONE and IDLE.
- SORT_SWAP_CNT_EN undefined: swap_cnt port and counter are absent; all other behaviour is identical.

Decomposition:
- sort_pkg holds the state enum sort_state_t (12 states, 4-bit encoding) and localparams for Csel/Bout encodings (SEL_I=0, SEL_J=1, OUT_A=0, OUT_B=1).
- No sub-module: the FSM is one next-state block plus one output decode block.
- The swap counter is an inline guarded register.

Test Plan:
- Reset mid-sort: assert rst in cycle 200 of a sort → outputs 0 and Li=1 asynchronously; busy=0, done=0; next go starts a fresh sort from RD_A.
- Already-sorted RAM 0..15: pulse go high and hold → busy high for exactly 510 cycles, Wr never 1, done=1, swap_cnt=0.
- Reverse RAM 15..0: go → busy for 990 cycles; readback 0..15 ascending; swap_cnt=120.
- All-equal RAM (sixteen 0x00AA words): go → 510 busy cycles, no Wr, contents unchanged.
- Random RAM with duplicates: go → readback is non-decreasing and a permutation of the input. Checker asserts Ei&Ej never both high, and that Wr occurs only with busy=1.
- Handshake: hold go=1 after done → stays in DONE with done=1 and no restart; drop go → IDLE next cycle, done=0; raise go → busy next cycle.
